gpio_irq_ctrl: RTL and testbench
================================

Name: gpio_irq_ctrl

Overview:
- Interrupt controller directly downstream of the 24-pin GPIO mux.
- Consumes the per-pin INTR lines and latches rising edges into pending bits.
- Arbitrates pending, unmasked sources by fixed priority and presents one vectored IRQ to the CPU with an ACK handshake.
- On acknowledge, drives the matching per-pin IRQRES pulse back into the mux to clear the pin's sticky interrupt.

Parameters:
- N_SRC, 24, number of interrupt sources (one per GPIO pin).
- ID_W, 5, width of IRQ_ID; must satisfy 2^ID_W >= N_SRC.
- RES_CYCLES, 2, width in clock cycles of the IRQRES pulse; legal range 1..15.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_N  input  1  asynchronous, active-low reset.
- INTR  input  N_SRC  per-pin interrupt lines from the GPIO mux; level, sticky until IRQRES.
- IRQ_MASK  input  N_SRC  1 = source enabled for arbitration.
- OVR_CLR  input  N_SRC  1-cycle pulse per bit; clears OVERRUN.
- IRQ_ACK  input  1  CPU acknowledge; sampled only in ASSERT.
- IRQ  output  1  interrupt request to the CPU.
- IRQ_ID  output  ID_W  index of the source being delivered; valid while IRQ=1.
- IRQRES  output  N_SRC  reset pulse to the GPIO mux, one-hot.
- PENDING  output  N_SRC  latched pending status.
- OVERRUN  output  N_SRC  sticky flag: an edge arrived while the bit was already pending.

Behaviour:
- Reset (RST_N=0, asynchronous): IRQ=0, IRQ_ID=0, IRQRES=0, PENDING=0, OVERRUN=0, intr_q=0, FSM=IDLE, counter=0.
- Edge detect: rise = INTR & ~intr_q, with intr_q registered every cycle.
  - A line already high when reset releases produces a rise on the first clock.
- PENDING[i]: set on rise[i]; cleared on the cycle ACK is accepted for i. Set wins over clear in the same cycle.
- Masked sources still latch PENDING but are excluded from arbitration.
- OVERRUN[i]: set when rise[i] occurs and PENDING[i]=1 and PENDING[i] is not being cleared that cycle. Cleared by OVR_CLR[i]. Set wins over clear.
- Arbitration: fixed priority, lowest index wins, over PENDING & IRQ_MASK.
- FSM states:
  - IDLE: if any eligible source, go to ASSERT; IRQ_ID <= winner index.
  - ASSERT: IRQ=1; IRQ_ID frozen; a newly pending higher-priority source does not pre-empt; a mask change on the latched source does not withdraw IRQ. On IRQ_ACK=1, clear PENDING[IRQ_ID], load counter=RES_CYCLES, go to CLEAR.
  - CLEAR: IRQ=0; IRQRES[IRQ_ID]=1 for exactly RES_CYCLES cycles; then go to IDLE with IRQRES=0.
- IRQ is a registered output. It rises the cycle after entering ASSERT and falls the cycle after ACK is accepted.
- IRQ_ACK is ignored in IDLE and CLEAR.
- Latency: INTR[i] first sampled high at edge k gives PENDING[i]=1 after edge k and IRQ=1 after edge k+1.
- Back-to-back delivery: after CLEAR, at least one IDLE cycle precedes the next ASSERT.
- A rise on the source currently in CLEAR re-sets PENDING (set wins). It is delivered later, even though the IRQRES in flight will also clear the pin.
- IRQ_ID above N_SRC-1 can never occur.
- Reset mid-operation: all state clears immediately. Any IRQRES pulse in progress is truncated.

Optional Feature:
- Macro: GPIO_IRQ_SYNC_EN.
- Defined: INTR passes through a 2-flop synchronizer (reset 0) before edge detect. Every INTR-to-PENDING/IRQ latency grows by 2 cycles.
- Not defined: INTR feeds edge detect directly. The mux outputs are then required to be synchronous to CLK.

Test Plan:
- Reset: hold RST_N=0 with INTR=24'hFFFFFF -> all outputs 0. After release, PENDING=24'hFFFFFF in 1 cycle, IRQ=1 with IRQ_ID=0 after 2 cycles.
- Single source: IRQ_MASK=all ones, pulse INTR[5] high and hold -> IRQ=1, IRQ_ID=5. ACK -> PENDING[5]=0, IRQRES=24'h000020 for exactly 2 cycles; drop INTR[5] -> IRQ stays 0.
- Priority/no pre-emption: INTR[9] rises, IRQ_ID=9 asserted; then INTR[2] rises before ACK -> IRQ_ID stays 9. After ACK and CLEAR, next delivery has IRQ_ID=2.
- Mask: IRQ_MASK=0, INTR[3] rises -> PENDING[3]=1, IRQ=0. Set IRQ_MASK[3]=1 -> IRQ=1 with IRQ_ID=3 after 1 cycle.
- Overrun: INTR[7] rises, falls, rises again before ACK -> OVERRUN[7]=1. OVR_CLR[7] pulse -> OVERRUN[7]=0. A simultaneous new rise keeps OVERRUN[7]=1.
- Reset mid-CLEAR: assert RST_N=0 during the first IRQRES cycle -> IRQRES=0 immediately, FSM=IDLE.

Source files
------------

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: vectored interrupt controller downstream of the 24-pin GPIO mux.
// Latches rising edges of the per-pin INTR lines into PENDING, tracks OVERRUN,
// arbitrates PENDING & IRQ_MASK by fixed priority (lowest index wins) and
// delivers one IRQ/IRQ_ID at a time with an ACK handshake. An accepted ACK
// launches a RES_CYCLES-wide one-hot IRQRES pulse back to the mux to clear the
// pin's sticky interrupt.
//
// Build option: define GPIO_IRQ_SYNC_EN to insert a 2-flop synchronizer on INTR
// ahead of edge detection (adds 2 cycles to every INTR-to-PENDING/IRQ latency).
// Without it, INTR must already be synchronous to CLK.
//
// Parameter constraints: 2**ID_W >= N_SRC, 1 <= RES_CYCLES <= 15.

module gpio_irq_ctrl #(
    parameter int N_SRC      = 24,
    parameter int ID_W       = 5,
    parameter int RES_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_SRC-1:0] INTR,
    input  logic [N_SRC-1:0] IRQ_MASK,
    input  logic [N_SRC-1:0] OVR_CLR,
    input  logic             IRQ_ACK,
    output logic             IRQ,
    output logic [ID_W-1:0]  IRQ_ID,
    output logic [N_SRC-1:0] IRQRES,
    output logic [N_SRC-1:0] PENDING,
    output logic [N_SRC-1:0] OVERRUN
);

    // Counter is sized for the full legal RES_CYCLES range (1..15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_CLEAR  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
`ifdef GPIO_IRQ_SYNC_EN
    logic [N_SRC-1:0] sync_meta_q, sync_meta_d;
    logic [N_SRC-1:0] sync_q,      sync_d;
`endif
    logic [N_SRC-1:0] intr_s;
    logic [N_SRC-1:0] intr_q,      intr_d;
    logic [N_SRC-1:0] rise;

    logic [N_SRC-1:0] pending_q,   pending_d;
    logic [N_SRC-1:0] overrun_q,   overrun_d;
    logic [N_SRC-1:0] clr_vec;

    logic [N_SRC-1:0] eligible;
    logic             any_eligible;
    logic [ID_W-1:0]  winner;
    logic [N_SRC-1:0] id_onehot;

    state_e           state_q,     state_d;
    logic             irq_q,       irq_d;
    logic [ID_W-1:0]  irq_id_q,    irq_id_d;
    logic [N_SRC-1:0] irqres_q,    irqres_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ack_accept;

    // ------------------------------------------------------------------
    // Input conditioning and rising-edge detection
    // ------------------------------------------------------------------

    // Select the edge-detector source (optionally synchronized) and form rise.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
`ifdef GPIO_IRQ_SYNC_EN
        sync_meta_d = INTR;
        sync_d      = sync_meta_q;
        intr_s      = sync_q;
`else
        intr_s      = INTR;
`endif
        intr_d = intr_s;
        // A line already high when reset releases is seen as a rise, since intr_q resets to 0.
        rise   = intr_s & ~intr_q;
    end

    // ------------------------------------------------------------------
    // Fixed-priority arbitration over pending, unmasked sources
    // ------------------------------------------------------------------

    // Lowest eligible index wins; scanning downwards lets the lowest overwrite last.
    always_comb begin
        eligible     = pending_q & IRQ_MASK;
        any_eligible = |eligible;
        winner       = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Decode the latched IRQ_ID into a one-hot source vector.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_onehot[i] = (irq_id_q == ID_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Delivery FSM: IDLE -> ASSERT -> CLEAR -> IDLE
    // ------------------------------------------------------------------

    // Next-state and registered-output logic for the delivery handshake.
    always_comb begin
        state_d    = state_q;
        irq_d      = irq_q;
        irq_id_d   = irq_id_q;
        irqres_d   = irqres_q;
        cnt_d      = cnt_q;
        ack_accept = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // IRQ is raised on the same edge that enters ASSERT.
                if (any_eligible) begin
                    state_d  = ST_ASSERT;
                    irq_d    = 1'b1;
                    irq_id_d = winner;
                end
            end

            ST_ASSERT: begin
                // IRQ_ID stays frozen here: no pre-emption, and mask changes are ignored.
                if (IRQ_ACK) begin
                    ack_accept = 1'b1;
                    state_d    = ST_CLEAR;
                    irq_d      = 1'b0;
                    irqres_d   = id_onehot;
                    cnt_d      = CNT_W'(RES_CYCLES);
                end
            end

            ST_CLEAR: begin
                // cnt_q counts the IRQRES cycles still to go, including the current one.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d  = ST_IDLE;
                    irqres_d = '0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                irq_d    = 1'b0;
                irqres_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PENDING / OVERRUN status
    // ------------------------------------------------------------------

    // Pending and overrun updates; a new rise always wins over a same-cycle clear.
    always_comb begin
        clr_vec   = ack_accept ? id_onehot : '0;
        pending_d = (pending_q & ~clr_vec) | rise;
        overrun_d = (overrun_q & ~OVR_CLR) | (rise & pending_q & ~clr_vec);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------

    // All flops, asynchronously cleared; reset also truncates any IRQRES pulse in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!RST_N) begin
`ifdef GPIO_IRQ_SYNC_EN
            sync_meta_q <= '0;
            sync_q      <= '0;
`endif
            intr_q      <= '0;
            pending_q   <= '0;
            overrun_q   <= '0;
            state_q     <= ST_IDLE;
            irq_q       <= 1'b0;
            irq_id_q    <= '0;
            irqres_q    <= '0;
            cnt_q       <= '0;
        end else begin
`ifdef GPIO_IRQ_SYNC_EN
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
`endif
            intr_q      <= intr_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            state_q     <= state_d;
            irq_q       <= irq_d;
            irq_id_q    <= irq_id_d;
            irqres_q    <= irqres_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign IRQ     = irq_q;
    assign IRQ_ID  = irq_id_q;
    assign IRQRES  = irqres_q;
    assign PENDING = pending_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_gpio_irq_ctrl;

    localparam int N_SRC      = 24;
    localparam int ID_W       = 5;
    localparam int RES_CYCLES = 2;
`ifdef GPIO_IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic             CLK;
    logic             RST_N;
    logic [N_SRC-1:0] INTR;
    logic [N_SRC-1:0] IRQ_MASK;
    logic [N_SRC-1:0] OVR_CLR;
    logic             IRQ_ACK;
    logic             IRQ;
    logic [ID_W-1:0]  IRQ_ID;
    logic [N_SRC-1:0] IRQRES;
    logic [N_SRC-1:0] PENDING;
    logic [N_SRC-1:0] OVERRUN;

    int n_assert = 0;
    int n_fail   = 0;

    gpio_irq_ctrl #(
        .N_SRC      (N_SRC),
        .ID_W       (ID_W),
        .RES_CYCLES (RES_CYCLES)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .INTR     (INTR),
        .IRQ_MASK (IRQ_MASK),
        .OVR_CLR  (OVR_CLR),
        .IRQ_ACK  (IRQ_ACK),
        .IRQ      (IRQ),
        .IRQ_ID   (IRQ_ID),
        .IRQRES   (IRQRES),
        .PENDING  (PENDING),
        .OVERRUN  (OVERRUN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural reference model ----------------
    logic [N_SRC-1:0] m_last;       // last sampled line values seen by edge detection
    logic [N_SRC-1:0] m_s1, m_s2;   // synchronizer delay line (used only with the sync option)
    logic [N_SRC-1:0] m_pend;
    logic [N_SRC-1:0] m_ovr;
    bit               m_irq;        // request currently presented to the CPU
    int               m_id;         // source being (or last) delivered
    int               m_res_left;   // IRQRES cycles still to be driven

    function automatic int lowest_set(input logic [N_SRC-1:0] v);
        int k = 0;
        while (k < N_SRC && !v[k]) k++;
        return k;
    endfunction

    function automatic void model_reset();
        m_last = '0; m_s1 = '0; m_s2 = '0;
        m_pend = '0; m_ovr = '0;
        m_irq = 1'b0; m_id = 0; m_res_left = 0;
    endfunction

    // One clock edge of the model, using the inputs as they stood before the edge.
    function automatic void model_edge();
        logic [N_SRC-1:0] seen, rise, clr;
        if (!RST_N) return;
`ifdef GPIO_IRQ_SYNC_EN
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = INTR;
`else
        seen = INTR;
`endif
        rise   = seen & ~m_last;
        m_last = seen;
        clr    = '0;
        if (m_res_left > 0) begin
            m_res_left--;                        // reset pulse running; ACK ignored
        end else if (m_irq) begin
            if (IRQ_ACK) begin
                clr[m_id]  = 1'b1;
                m_irq      = 1'b0;
                m_res_left = RES_CYCLES;
            end
        end else if ((m_pend & IRQ_MASK) != '0) begin
            m_id  = lowest_set(m_pend & IRQ_MASK);
            m_irq = 1'b1;
        end
        m_ovr  = (m_ovr & ~OVR_CLR) | (rise & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | rise;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [N_SRC-1:0] obs, input logic [N_SRC-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [N_SRC-1:0] exp_res;
        exp_res = '0;
        if (m_res_left > 0) exp_res[m_id] = 1'b1;
        check({tag, ".irq"},     N_SRC'(IRQ),    N_SRC'(m_irq));
        check({tag, ".irq_id"},  N_SRC'(IRQ_ID), N_SRC'(m_id));
        check({tag, ".irqres"},  IRQRES,         exp_res);
        check({tag, ".pending"}, PENDING,        m_pend);
        check({tag, ".overrun"}, OVERRUN,        m_ovr);
    endtask

    // Advance one clock, update the model, then compare shortly after the edge.
    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N_SRC-1:0] flip, one_hot;

        // Reset held with every line high.
        RST_N = 1'b0; INTR = '1; IRQ_MASK = '1; OVR_CLR = '0; IRQ_ACK = 1'b0;
        model_reset();
        #1;
        compare_all("rst_hold");
        check("rst_irq", N_SRC'(IRQ), '0);
        check("rst_pending", PENDING, '0);
        steps("rst_hold", 2);
        RST_N = 1'b1;
        steps("rst_sync", SYNC_LAT);
        step("rst_rel1");
        check("rst_rel_pending_all", PENDING, 24'hFFFFFF);
        check("rst_rel_irq_low", N_SRC'(IRQ), '0);
        step("rst_rel2");
        check("rst_rel_irq", N_SRC'(IRQ), N_SRC'(1));
        check("rst_rel_id0", N_SRC'(IRQ_ID), '0);

        // Clean restart with all lines low.
        RST_N = 1'b0; INTR = '0;
        model_reset();
        #1;
        compare_all("rst2");
        steps("rst2", 2);
        RST_N = 1'b1;
        steps("idle", 3);

        // Single source 5.
        INTR[5] = 1'b1;
        steps("s5_sync", SYNC_LAT);
        step("s5_pend");
        check("s5_pending", PENDING, 24'h000020);
        step("s5_irq");
        check("s5_irq", N_SRC'(IRQ), N_SRC'(1));
        check("s5_id", N_SRC'(IRQ_ID), N_SRC'(5));
        IRQ_ACK = 1'b1;
        step("s5_ack");
        IRQ_ACK = 1'b0;
        check("s5_pend_clr", PENDING, '0);
        check("s5_res1", IRQRES, 24'h000020);
        check("s5_irq_fall", N_SRC'(IRQ), '0);
        step("s5_res2");
        check("s5_res2", IRQRES, 24'h000020);
        step("s5_res_end");
        check("s5_res_end", IRQRES, '0);
        INTR[5] = 1'b0;
        steps("s5_drop", 3 + SYNC_LAT);
        check("s5_quiet", N_SRC'(IRQ), '0);

        // Priority without pre-emption: 9 then 2.
        INTR[9] = 1'b1;
        steps("p9", SYNC_LAT + 2);
        check("p9_id", N_SRC'(IRQ_ID), N_SRC'(9));
        INTR[2] = 1'b1;
        steps("p2_rise", SYNC_LAT + 2);
        check("p_no_preempt_irq", N_SRC'(IRQ), N_SRC'(1));
        check("p_no_preempt_id", N_SRC'(IRQ_ID), N_SRC'(9));
        IRQ_ACK = 1'b1;
        step("p9_ack");
        IRQ_ACK = 1'b0;
        steps("p9_clear", RES_CYCLES);
        check("p_idle_gap", N_SRC'(IRQ), '0);
        step("p2_assert");
        check("p2_irq", N_SRC'(IRQ), N_SRC'(1));
        check("p2_id", N_SRC'(IRQ_ID), N_SRC'(2));
        IRQ_ACK = 1'b1;
        step("p2_ack");
        IRQ_ACK = 1'b0;
        INTR = '0;
        steps("p_drain", RES_CYCLES + SYNC_LAT + 2);

        // Masked source still latches pending; unmasking delivers one cycle later.
        IRQ_MASK = '0;
        INTR[3] = 1'b1;
        steps("m3", SYNC_LAT + 3);
        check("m3_pending", PENDING[3] ? N_SRC'(1) : '0, N_SRC'(1));
        check("m3_irq_masked", N_SRC'(IRQ), '0);
        IRQ_MASK[3] = 1'b1;
        step("m3_unmask");
        check("m3_irq", N_SRC'(IRQ), N_SRC'(1));
        check("m3_id", N_SRC'(IRQ_ID), N_SRC'(3));
        IRQ_MASK = '0;                          // mask change does not withdraw
        step("m3_remask");
        check("m3_hold", N_SRC'(IRQ), N_SRC'(1));
        IRQ_MASK = '1;
        IRQ_ACK = 1'b1;
        step("m3_ack");
        IRQ_ACK = 1'b0;
        INTR = '0;
        steps("m_drain", RES_CYCLES + SYNC_LAT + 2);

        // Overrun on source 7.
        INTR[7] = 1'b1;
        steps("o7", SYNC_LAT + 2);
        INTR[7] = 1'b0;
        step("o7_fall");
        INTR[7] = 1'b1;
        steps("o7_sync", SYNC_LAT);
        step("o7_rerise");
        check("o7_set", OVERRUN, 24'h000080);
        OVR_CLR[7] = 1'b1;
        step("o7_clr");
        OVR_CLR = '0;
        check("o7_cleared", OVERRUN, '0);
        INTR[7] = 1'b0;
        step("o7_fall2");
        INTR[7] = 1'b1;
        steps("o7_sync2", SYNC_LAT);
        OVR_CLR[7] = 1'b1;
        step("o7_set_wins");
        OVR_CLR = '0;
        check("o7_set_wins", OVERRUN, 24'h000080);
        IRQ_ACK = 1'b1;
        step("o7_ack");
        IRQ_ACK = 1'b0;
        INTR = '0;
        OVR_CLR = '1;
        step("o7_ovr_clr_all");
        OVR_CLR = '0;
        steps("o_drain", RES_CYCLES + SYNC_LAT + 2);

        // Reset during the first IRQRES cycle.
        INTR[4] = 1'b1;
        steps("r4", SYNC_LAT + 2);
        IRQ_ACK = 1'b1;
        step("r4_ack");
        IRQ_ACK = 1'b0;
        check("r4_res_on", IRQRES, 24'h000010);
        RST_N = 1'b0;
        model_reset();
        #1;
        compare_all("r4_rst");
        check("r4_res_trunc", IRQRES, '0);
        steps("r4_rst_hold", 2);
        RST_N = 1'b1;
        steps("r4_restart", SYNC_LAT + 2);
        check("r4_redeliver_id", N_SRC'(IRQ_ID), N_SRC'(4));
        IRQ_ACK = 1'b1;
        step("r4_ack2");
        IRQ_ACK = 1'b0;
        INTR = '0;
        steps("r_drain", RES_CYCLES + SYNC_LAT + 2);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            flip = '0;
            for (int b = 0; b < N_SRC; b++) begin
                if ($urandom_range(0, 15) == 0) flip[b] = 1'b1;
            end
            INTR = INTR ^ flip;
            if ($urandom_range(0, 31) == 0) IRQ_MASK = N_SRC'($urandom);
            OVR_CLR = N_SRC'($urandom & $urandom & $urandom);
            IRQ_ACK = ($urandom_range(0, 2) == 0);
            step("rnd");
        end

        // Single-source sweep of every index through the full handshake.
        IRQ_ACK = 1'b0; OVR_CLR = '0; IRQ_MASK = '1; INTR = '0;
        RST_N = 1'b0;
        model_reset();
        #1;
        compare_all("sweep_rst");
        RST_N = 1'b1;
        for (int s = 0; s < N_SRC; s++) begin
            one_hot = '0;
            one_hot[s] = 1'b1;
            INTR = one_hot;
            steps("sweep", SYNC_LAT + 2);
            check("sweep_id", N_SRC'(IRQ_ID), N_SRC'(s));
            IRQ_ACK = 1'b1;
            step("sweep_ack");
            IRQ_ACK = 1'b0;
            check("sweep_res", IRQRES, one_hot);
            INTR = '0;
            steps("sweep_drain", RES_CYCLES + SYNC_LAT + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
